// File: rtl/elev_defs_pkg.sv
// Shared definitions for the elevator request scheduler.
// Holds the floor index width, the FSM state encoding, the direction
// encoding and two small helpers that scan the pending-request bitmap.
package elev_defs;

  localparam int FLOOR_W    = 2;
  localparam int NUM_FLOORS = 1 << FLOOR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // True when any pending floor lies strictly beyond 'floor' in direction 'dir'.
  function automatic logic any_ahead(input logic [NUM_FLOORS-1:0] pend,
                                     input logic [FLOOR_W-1:0]    floor,
                                     input logic                  dir);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i] && (((dir == DIR_UP) && (i > int'(floor))) ||
                      ((dir == DIR_DOWN) && (i < int'(floor))))) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Nearest pending floor at or beyond 'floor' in direction 'dir';
  // returns 'floor' itself when nothing is pending that way.
  function automatic logic [FLOOR_W-1:0] nearest(input logic [NUM_FLOORS-1:0] pend,
                                                 input logic [FLOOR_W-1:0]    floor,
                                                 input logic                  dir);
    logic [FLOOR_W-1:0] res;
    res = floor;
    if (dir == DIR_UP) begin
      // Scan top-down so the last hit is the smallest floor >= current.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (pend[i] && (i >= int'(floor))) res = FLOOR_W'(i);
      end
    end else begin
      // Scan bottom-up so the last hit is the largest floor <= current.
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (pend[i] && (i <= int'(floor))) res = FLOOR_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/elev_door_timer.sv
// Door hold timer.
// A load pulse (re)starts a down-counter at DOOR_CYCLES; door_open is high
// while the counter is non-zero, and expire flags the last open cycle
// (count == 1) so the scheduler can leave DOOR on the same edge the door shuts.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : start or restart the hold period
//   door_open   : registered door command
//   expire      : high during the final open cycle
module elev_door_timer #(
  parameter int DOOR_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic door_open,
  output logic expire
);

  localparam int CNT_W = $clog2(DOOR_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             door_open_q, door_open_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(DOOR_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    door_open_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      door_open_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      door_open_q <= door_open_d;
    end
  end

  assign door_open = door_open_q;
  assign expire    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN-policy sequencing controller for a 4-floor elevator car.
// Latches floor requests into a pending bitmap, keeps travelling in the
// current direction while requests remain ahead, opens the door for
// DOOR_CYCLES at each serviced floor, and tracks the floor from move_done.
// Optional build macro: ELEV_DOOR_REOPEN_EN -- a request for the current
// floor while the door is open restarts the door hold period.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   req_valid/req_floor : request strobe and floor
//   move_done      : car has travelled one floor in the commanded direction
//   motor_up/motor_down, door_open : registered actuator commands
//   actual_floor, down_up_Flag, target_floor, pending, busy : status
//   dbg_state      : current FSM state (ST_IDLE/ST_MOVE/ST_DOOR encoding)
// Handshake: req_valid is a plain strobe with no ready; every asserted cycle
// is one request, consumed at the next rising edge.
module elevator_request_scheduler
  import elev_defs::*;
#(
  parameter int DOOR_CYCLES = 16,
  parameter int INIT_FLOOR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  move_done,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    actual_floor,
  output logic                  down_up_Flag,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      actual_floor_q, actual_floor_d;
  logic                    dir_q, dir_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [FLOOR_W-1:0]      target_floor_q, target_floor_d;
  logic                    motor_up_q, motor_up_d;
  logic                    motor_down_q, motor_down_d;
  logic                    busy_q, busy_d;

  logic [NUM_FLOORS-1:0]   req_vec, set_vec, clr_vec, pend_arrive;
  logic                    door_same, door_reload, door_load, door_expire;

  elev_door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (door_load),
    .door_open (door_open),
    .expire    (door_expire)
  );

  always_comb begin
    req_vec = '0;
    if (req_valid) req_vec[req_floor] = 1'b1;

    // A request for the floor whose door is already open is never latched.
    door_same = (state_q == ST_DOOR) && req_valid && (req_floor == actual_floor_q);
`ifdef ELEV_DOOR_REOPEN_EN
    door_reload = door_same;
`else
    door_reload = 1'b0;
`endif
    set_vec = door_same ? '0 : req_vec;
    // Arrival decisions also see this cycle's request, so a request that
    // lands together with move_done still stops the car.
    pend_arrive = pending_q | set_vec;

    state_d        = state_q;
    actual_floor_d = actual_floor_q;
    dir_d          = dir_q;
    clr_vec        = '0;
    door_load      = door_reload;

    case (state_q)
      ST_IDLE: begin
        if (pending_q[actual_floor_q]) begin
          state_d                 = ST_DOOR;
          clr_vec[actual_floor_q] = 1'b1;
          door_load               = 1'b1;
        end else if (any_ahead(pending_q, actual_floor_q, dir_q)) begin
          state_d = ST_MOVE;
        end else if (any_ahead(pending_q, actual_floor_q, ~dir_q)) begin
          dir_d   = ~dir_q;
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (move_done) begin
          if (((dir_q == DIR_UP) && (actual_floor_q == FLOOR_W'(NUM_FLOORS - 1))) ||
              ((dir_q == DIR_DOWN) && (actual_floor_q == '0))) begin
            // Travel past either end is impossible; hold position and stop.
            state_d = ST_IDLE;
          end else begin
            actual_floor_d = (dir_q == DIR_UP) ? actual_floor_q + FLOOR_W'(1)
                                               : actual_floor_q - FLOOR_W'(1);
            if (pend_arrive[actual_floor_d]) begin
              state_d                 = ST_DOOR;
              clr_vec[actual_floor_d] = 1'b1;
              door_load               = 1'b1;
            end else if (any_ahead(pend_arrive, actual_floor_d, dir_q)) begin
              state_d = ST_MOVE;
            end else if (any_ahead(pend_arrive, actual_floor_d, ~dir_q)) begin
              dir_d = ~dir_q;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_DOOR: begin
        if (door_expire && !door_reload) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clears only occur when a door opens at that floor, so clear-over-set
    // here is exactly the required conflict rule.
    pending_d      = (pending_q | set_vec) & ~clr_vec;
    target_floor_d = nearest(pending_q, actual_floor_q, dir_q);
    motor_up_d     = (state_d == ST_MOVE) && (dir_d == DIR_UP);
    motor_down_d   = (state_d == ST_MOVE) && (dir_d == DIR_DOWN);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      actual_floor_q <= FLOOR_W'(INIT_FLOOR);
      dir_q          <= DIR_UP;
      pending_q      <= '0;
      target_floor_q <= FLOOR_W'(INIT_FLOOR);
      motor_up_q     <= 1'b0;
      motor_down_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      actual_floor_q <= actual_floor_d;
      dir_q          <= dir_d;
      pending_q      <= pending_d;
      target_floor_q <= target_floor_d;
      motor_up_q     <= motor_up_d;
      motor_down_q   <= motor_down_d;
      busy_q         <= busy_d;
    end
  end

  assign motor_up     = motor_up_q;
  assign motor_down   = motor_down_q;
  assign actual_floor = actual_floor_q;
  assign down_up_Flag = dir_q;
  assign target_floor = target_floor_q;
  assign pending      = pending_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Testbench for elevator_request_scheduler (DOOR_CYCLES = 4).
// Stops are scoreboarded: each scenario pushes the stops it expects as
// {floor, direction, pending at door open, door-open length}; a negedge
// monitor rebuilds the same word whenever the door closes and pops/compares.
// Inline checks cover reset values, motors, floors and target_floor.
module tb_elevator_request_scheduler;

  localparam int FW = 2;
  localparam int NF = 4;
  localparam int DC = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
`ifdef ELEV_DOOR_REOPEN_EN
  localparam int REOPEN_LEN = DC + 1;
`else
  localparam int REOPEN_LEN = DC;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          move_done = 1'b0;
  logic          motor_up, motor_down, door_open, down_up_Flag, busy;
  logic [FW-1:0] actual_floor, target_floor;
  logic [NF-1:0] pending;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [14:0] exp_q[$];

  elevator_request_scheduler #(.DOOR_CYCLES(DC), .INIT_FLOOR(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .move_done    (move_done),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .actual_floor (actual_floor),
    .down_up_Flag (down_up_Flag),
    .target_floor (target_floor),
    .pending      (pending),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic req(input logic [FW-1:0] f);
    req_valid = 1'b1;
    req_floor = f;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic mdone();
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
  endtask

  task automatic push_stop(input logic [FW-1:0] f, input logic d,
                           input logic [NF-1:0] p, input int len);
    exp_q.push_back({f, d, p, 8'(len)});
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    int waited;
    waited = 0;
    while (dbg_state != st && waited < 40) begin
      tick();
      waited++;
    end
    if (dbg_state != st) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got state %0d expected %0d (timeout)", name, dbg_state, st);
    end
  endtask

  task automatic wait_idle(input string name);
    int waited;
    waited = 0;
    while ((dbg_state != S_IDLE || door_open) && waited < 40) begin
      tick();
      waited++;
    end
    if (dbg_state != S_IDLE || door_open) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got state %0d expected idle (timeout)", name, dbg_state);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},   dbg_state,    S_IDLE);
    check({tag, "_pending"}, pending,      4'b0000);
    check({tag, "_floor"},   actual_floor, 2'd0);
    check({tag, "_dir"},     down_up_Flag, 1'b1);
    check({tag, "_motors"},  {motor_up, motor_down}, 2'b00);
    check({tag, "_door"},    door_open,    1'b0);
    check({tag, "_busy"},    busy,         1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        door_prev = 1'b0;
  int          door_len = 0;
  logic [6:0]  obs_head = '0;
  logic [14:0] obs_word;
  logic        both_seen = 1'b0;
  logic        motor_in_door = 1'b0;
  logic        any_motor = 1'b0;

  always @(negedge clk) begin
    if (motor_up && motor_down) both_seen = 1'b1;
    if (door_open && (motor_up || motor_down)) motor_in_door = 1'b1;
    if (motor_up || motor_down) any_motor = 1'b1;
    if (door_open && !door_prev) begin
      obs_head = {actual_floor, down_up_Flag, pending};
      door_len = 1;
    end else if (door_open) begin
      door_len++;
    end
    if (!door_open && door_prev) begin
      obs_word = {obs_head, 8'(door_len)};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL stop_unexpected: got %h expected none", obs_word);
      end else begin
        check("stop", 32'(obs_word), 32'(exp_q.pop_front()));
      end
    end
    door_prev = door_open;
  end

  // ---------------- stimulus ----------------
  initial begin
    // 1: request at the current floor opens the door only.
    do_reset();
    check_reset_vals("rst");
    any_motor = 1'b0;
    push_stop(2'd0, 1'b1, 4'b0000, DC);
    req(2'd0);
    check("t1_pending_set", pending, 4'b0001);
    check("t1_still_idle", dbg_state, S_IDLE);
    tick();
    check("t1_door", door_open, 1'b1);
    check("t1_pending_clr", pending, 4'b0000);
    wait_idle("t1_idle");
    check("t1_no_motor", any_motor, 1'b0);

    // 2: floor 0 -> 2 upward.
    push_stop(2'd2, 1'b1, 4'b0000, DC);
    req(2'd2);
    wait_state(S_MOVE, "t2_move");
    check("t2_motors", {motor_up, motor_down}, 2'b10);
    check("t2_target", target_floor, 2'd2);
    mdone();
    check("t2_floor1", actual_floor, 2'd1);
    check("t2_up_still", motor_up, 1'b1);
    mdone();
    check("t2_floor2", actual_floor, 2'd2);
    check("t2_door", door_open, 1'b1);
    check("t2_dir", down_up_Flag, 1'b1);
    check("t2_target_stop", target_floor, 2'd2);
    wait_idle("t2_idle");

    // 3: SCAN: service 3 first, then reverse to 0.
    do_reset();
    push_stop(2'd3, 1'b1, 4'b0001, DC);
    push_stop(2'd0, 1'b0, 4'b0000, DC);
    req(2'd3);
    req(2'd0);
    check("t3_move", dbg_state, S_MOVE);
    mdone();
    check("t3_pend", pending, 4'b1001);
    mdone();
    mdone();
    check("t3_at3", actual_floor, 2'd3);
    wait_state(S_MOVE, "t3_reverse");
    check("t3_dir_down", down_up_Flag, 1'b0);
    check("t3_motors_down", {motor_up, motor_down}, 2'b01);
    mdone();
    check("t3_target_down", target_floor, 2'd0);
    mdone();
    mdone();
    check("t3_at0", actual_floor, 2'd0);
    wait_idle("t3_idle");

    // 4: same-floor request while the door is open.
    do_reset();
    push_stop(2'd2, 1'b1, 4'b0000, REOPEN_LEN);
    req(2'd2);
    wait_state(S_MOVE, "t4_move");
    mdone();
    mdone();
    check("t4_door", door_open, 1'b1);
    req(2'd2);
    wait_idle("t4_idle");
    check("t4_pending", pending, 4'b0000);

    // 5: reset mid-move.
    do_reset();
    req(2'd3);
    req(2'd0);
    mdone();
    mdone();
    check("t5_floor2", actual_floor, 2'd2);
    check("t5_pend", pending, 4'b1001);
    check("t5_moving", motor_up, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("t5");

    // 6: requests coinciding with move_done.
    do_reset();
    push_stop(2'd1, 1'b1, 4'b1000, DC);
    push_stop(2'd3, 1'b1, 4'b0001, DC);
    push_stop(2'd0, 1'b0, 4'b0000, DC);
    req(2'd3);
    wait_state(S_MOVE, "t6_move");
    move_done = 1'b1;
    req_valid = 1'b1;
    req_floor = 2'd1;
    tick();
    move_done = 1'b0;
    req_valid = 1'b0;
    check("t6_stop1_floor", actual_floor, 2'd1);
    check("t6_stop1_door", door_open, 1'b1);
    check("t6_stop1_pend", pending, 4'b1000);
    wait_state(S_MOVE, "t6_resume");
    move_done = 1'b1;
    req_valid = 1'b1;
    req_floor = 2'd0;
    tick();
    move_done = 1'b0;
    req_valid = 1'b0;
    check("t6_floor2", actual_floor, 2'd2);
    check("t6_pend_other", pending, 4'b1001);
    check("t6_continue", {motor_up, motor_down, door_open}, 3'b100);
    mdone();
    wait_state(S_MOVE, "t6_reverse");
    mdone();
    mdone();
    mdone();
    wait_idle("t6_idle");
    mdone();
    check("t6_ignored_floor", actual_floor, 2'd0);
    check("t6_ignored_state", dbg_state, S_IDLE);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    check("motor_exclusive", both_seen, 1'b0);
    check("motor_off_in_door", motor_in_door, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
